seq_detector_n: RTL and testbench

SEQ_DETECTOR_N -- requirements
Module: seq_detector_n

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_detector_n_sat_counter.sv | 28 ++
 rtl/seq_detector_n.sv | 140 ++++++++++++++
 tb/tb_seq_detector_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial pattern detector.
package seq_det_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    LOCK
  } state_t;

endpackage

// File: rtl/seq_detector_n_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_n.sv
// Serial N-bit pattern detector with overlap control, strict-prefix lock
// mode and a saturating match counter. All outputs come straight from flops.
module seq_detector_n
  import seq_det_pkg::*;
#(
  parameter int           N       = DEF_N,
  parameter int           CNT_W   = DEF_CNT_W,
  parameter logic [N-1:0] PAT_RST = N'(4'b1011)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_x,
  input  logic [N-1:0]           i_pattern,
  input  logic                   i_load,
  input  logic                   i_clr,
  input  logic                   i_overlap,
  input  logic                   i_lock_en,
  output logic                   o_match,
  output logic                   o_locked,
  output logic [$clog2(N+1)-1:0] o_fill,
  output logic [CNT_W-1:0]       o_match_cnt
);

  localparam int                FILL_W   = $clog2(N+1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  // Only N-1 history bits are stored; the oldest bit always falls off on the next shift.
  logic [N-2:0]      r_hist;
  logic [N-2:0]      w_hist_nxt;
  logic [N-1:0]      r_pat;
  logic [N-1:0]      w_hist_shift;
  logic [N-1:0]      w_pat_pfx;
  logic [N-1:0]      w_mask;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [FILL_W-1:0] w_fill_inc;
  logic              r_match;
  logic              r_locked;
  logic              w_match_nxt;
  logic              w_locked_nxt;
  logic              w_accept;
  logic              w_strict;
  logic              w_pfx_ok;
  logic              w_hit;

  assign w_accept     = i_en && !i_load && !i_clr;
  assign w_hist_shift = {r_hist, i_x};
  assign w_fill_inc   = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_ONE;
  assign w_strict     = i_lock_en && ((r_state == IDLE) || (r_state == FILL));

  // Align the leading fill+1 pattern bits with the newest history bits.
  assign w_pat_pfx = r_pat >> (FILL_MAX - FILL_ONE - r_fill);
  assign w_mask    = ~({N{1'b1}} << (r_fill + FILL_ONE));
  assign w_pfx_ok  = ((w_hist_shift ^ w_pat_pfx) & w_mask) == '0;
  assign w_hit     = (w_fill_inc == FILL_MAX) && (w_hist_shift == r_pat);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_hist   <= '0;
      r_fill   <= '0;
      r_match  <= 1'b0;
      r_locked <= 1'b0;
      r_pat    <= PAT_RST;
    end else begin
      r_state  <= w_state_nxt;
      r_hist   <= w_hist_nxt;
      r_fill   <= w_fill_nxt;
      r_match  <= w_match_nxt;
      r_locked <= w_locked_nxt;
      if (!i_clr && i_load) begin
        r_pat <= i_pattern;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clr || i_load) begin
      w_state_nxt = IDLE;
    end else if (w_accept && (r_state != LOCK)) begin
      if (w_strict && !w_pfx_ok) begin
        w_state_nxt = (r_state == FILL) ? LOCK : IDLE;
      end else if (w_hit) begin
        w_state_nxt = i_overlap ? FULL : IDLE;
      end else begin
        w_state_nxt = (w_fill_inc == FILL_MAX) ? FULL : FILL;
      end
    end
  end

  // A broken prefix in IDLE just drops the bit; only a broken prefix in FILL locks.
  always_comb begin
    w_hist_nxt   = r_hist;
    w_fill_nxt   = r_fill;
    w_match_nxt  = 1'b0;
    w_locked_nxt = r_locked;
    if (i_clr) begin
      w_hist_nxt   = '0;
      w_fill_nxt   = '0;
      w_locked_nxt = 1'b0;
    end else if (i_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (w_accept && (r_state != LOCK)) begin
      if (w_strict && !w_pfx_ok) begin
        if (r_state == FILL) begin
          w_locked_nxt = 1'b1;
        end
      end else if (w_hit && !i_overlap) begin
        w_hist_nxt  = '0;
        w_fill_nxt  = '0;
        w_match_nxt = 1'b1;
      end else begin
        w_hist_nxt  = w_hist_shift[N-2:0];
        w_fill_nxt  = w_fill_inc;
        w_match_nxt = w_hit;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_match_nxt),
    .i_clr   (i_clr),
    .o_count (o_match_cnt)
  );

  assign o_match  = r_match;
  assign o_locked = r_locked;
  assign o_fill   = r_fill;

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed and random checks of seq_detector_n against a queue-based reference
// model; a second instance with a 2-bit counter exercises saturation.
module tb_seq_detector_n;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       load = 1'b0;
  logic       clr = 1'b0;
  logic       overlap = 1'b1;
  logic       lockEn = 1'b0;

  logic       matchA, lockedA, matchB, lockedB;
  logic [2:0] fillA, fillB;
  logic [7:0] cntA;
  logic [1:0] cntB;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model state
  bit         mHist[$];
  int         mFill = 0;
  int         mCnt = 0;
  bit         mMatch = 0;
  bit         mInLock = 0;
  bit         mLockFlag = 0;
  logic [3:0] mPat = 4'b1011;

  always #5 clk = ~clk;

  seq_detector_n dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_x(x), .i_pattern(pattern),
    .i_load(load), .i_clr(clr), .i_overlap(overlap), .i_lock_en(lockEn),
    .o_match(matchA), .o_locked(lockedA), .o_fill(fillA), .o_match_cnt(cntA)
  );

  seq_detector_n #(.CNT_W(2)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_x(x), .i_pattern(pattern),
    .i_load(load), .i_clr(clr), .i_overlap(overlap), .i_lock_en(lockEn),
    .o_match(matchB), .o_locked(lockedB), .o_fill(fillB), .o_match_cnt(cntB)
  );

  function automatic bit leadsPattern(input bit bits[$]);
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i] != mPat[N-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic acceptSample(input bit xi);
    bit cand[$];
    mMatch = 1'b0;
    if (mInLock) return;
    cand = mHist;
    cand.push_back(xi);
    if (lockEn && (mFill < N) && !leadsPattern(cand)) begin
      if (mFill > 0) begin
        mInLock   = 1'b1;
        mLockFlag = 1'b1;
      end
      return;
    end
    if (cand.size() > N) void'(cand.pop_front());
    mHist = cand;
    if (mFill < N) mFill++;
    mMatch = (mFill == N) && leadsPattern(mHist);
    if (mMatch) begin
      mCnt++;
      if (!overlap) begin
        mHist.delete();
        mFill = 0;
      end
    end
  endtask

  task automatic modelEdge();
    if (!rstN) begin
      mPat = 4'b1011; mHist.delete(); mFill = 0; mCnt = 0;
      mMatch = 0; mInLock = 0; mLockFlag = 0;
    end else if (clr) begin
      mHist.delete(); mFill = 0; mCnt = 0;
      mMatch = 0; mInLock = 0; mLockFlag = 0;
    end else if (load) begin
      mPat = pattern; mHist.delete(); mFill = 0; mMatch = 0; mInLock = 0;
    end else if (en) begin
      acceptSample(x);
    end else begin
      mMatch = 0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    assert (act === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/matchA"}, 32'(matchA), 32'(mMatch));
    checkVal({tag, "/lockedA"}, 32'(lockedA), 32'(mLockFlag));
    checkVal({tag, "/fillA"}, 32'(fillA), 32'(mFill));
    checkVal({tag, "/cntA"}, 32'(cntA), 32'((mCnt > 255) ? 255 : mCnt));
    checkVal({tag, "/matchB"}, 32'(matchB), 32'(mMatch));
    checkVal({tag, "/lockedB"}, 32'(lockedB), 32'(mLockFlag));
    checkVal({tag, "/fillB"}, 32'(fillB), 32'(mFill));
    checkVal({tag, "/cntB"}, 32'(cntB), 32'((mCnt > 3) ? 3 : mCnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input bit xi, input string tag);
    en = 1'b1;
    x  = xi;
    tick(tag);
    en = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
  endtask

  initial begin
    bit [6:0] stream;
    bit [6:0] exp37;
    bit [6:0] exp38;
    bit [3:0] word;
    int       pulses;

    stream = 7'b1011011;
    exp37  = 7'b0001001;
    exp38  = 7'b0001000;
    word   = 4'b1011;

    tick("reset0");
    tick("reset1");
    rstN = 1'b1;

    lockEn = 1'b0; overlap = 1'b1;
    pulseClr();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stream[6-i], "ovl");
      checkVal("ovl_pulse", 32'(matchA), 32'(exp37[6-i]));
    end
    checkVal("ovl_cnt", 32'(cntA), 32'd2);

    overlap = 1'b0;
    pulseClr();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stream[6-i], "novl");
      checkVal("novl_pulse", 32'(matchA), 32'(exp38[6-i]));
    end
    checkVal("novl_fill", 32'(fillA), 32'd3);
    checkVal("novl_cnt", 32'(cntA), 32'd1);

    lockEn = 1'b1; overlap = 1'b1;
    pulseClr();
    applyStimulus(1'b1, "lock");
    applyStimulus(1'b1, "lock");
    checkVal("lock_set", 32'(lockedA), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(word[3-i], "locked");
      checkVal("locked_nomatch", 32'(matchA), 32'd0);
    end
    pulseClr();
    checkVal("unlock_flag", 32'(lockedA), 32'd0);
    checkVal("unlock_fill", 32'(fillA), 32'd0);

    applyStimulus(1'b0, "discard");
    applyStimulus(1'b0, "discard");
    checkVal("discard_fill", 32'(fillA), 32'd0);
    checkVal("discard_lock", 32'(lockedA), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(word[3-i], "strict");
    checkVal("strict_match", 32'(matchA), 32'd1);

    lockEn = 1'b0; overlap = 1'b0;
    pulseClr();
    pulses = 0;
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(word[3-i], "sat");
        if (matchB) pulses++;
      end
    end
    checkVal("sat_pulses", 32'(pulses), 32'd5);
    checkVal("sat_cntB", 32'(cntB), 32'd3);

    applyStimulus(1'b1, "prefill");
    applyStimulus(1'b0, "prefill");
    rstN = 1'b0; load = 1'b1; en = 1'b1; pattern = 4'b0110; x = 1'b1;
    tick("rst_over_load");
    rstN = 1'b1; load = 1'b0; en = 1'b0;
    checkVal("rst_cntA", 32'(cntA), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(word[3-i], "post_rst");
    checkVal("post_rst_pat", 32'(matchA), 32'd1);

    pattern = 4'b0110; load = 1'b1;
    tick("load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(pattern[3-i], "new_pat");
    checkVal("new_pat_match", 32'(matchA), 32'd1);

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(31) == 0) overlap = ~overlap;
      if ($urandom_range(31) == 0) lockEn = ~lockEn;
      rstN    = ($urandom_range(149) != 0);
      clr     = ($urandom_range(59) == 0);
      load    = ($urandom_range(49) == 0);
      pattern = 4'($urandom_range(15));
      en      = ($urandom_range(7) != 0);
      x       = 1'($urandom_range(1));
      tick("rand");
    end
    rstN = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
